// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: the PRGA decryptor's state encoding and message length,
// plus the key-scheduling controller's constants.
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;
    localparam int MSG_AW      = 5;
    localparam int S_SIZE      = 256;
    localparam int KEY_LEN     = 3;

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        LATCH_SI,
        RD_SJ,
        LATCH_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        LATCH_F,
        DONE
    } prga_state_t;

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generator over a pre-scheduled S memory; XORs each keystream byte
// with the ciphertext ROM and writes the plaintext RAM, one byte per 9 cycles.
module rc4_prga_decryptor
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] out_address,
    output logic [7:0]        out_data,
    output logic              out_wren
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    prga_state_t       r_state;
    prga_state_t       w_next_state;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [MSG_AW-1:0] r_k;
    logic              w_accept;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                INC_I:    r_i <= add8(r_i, 8'd1);
                LATCH_SI: begin
                    r_si <= s_q;
                    r_j  <= add8(r_j, s_q);
                end
                LATCH_SJ: r_sj <= s_q;
                LATCH_F: begin
                    if (r_k != K_LAST) r_k <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode purely from state so an asynchronous reset clears them at once.
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        s_address    = '0;
        s_data       = '0;
        s_wren       = 1'b0;
        rom_address  = '0;
        out_address  = '0;
        out_data     = '0;
        out_wren     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = INC_I;
            end
            INC_I:    w_next_state = RD_SI;
            RD_SI: begin
                s_address    = r_i;
                w_next_state = LATCH_SI;
            end
            LATCH_SI: w_next_state = RD_SJ;
            RD_SJ: begin
                s_address    = r_j;
                w_next_state = LATCH_SJ;
            end
            LATCH_SJ: w_next_state = WR_SI;
            WR_SI: begin
                s_address    = r_i;
                s_data       = r_sj;
                s_wren       = 1'b1;
                w_next_state = WR_SJ;
            end
            WR_SJ: begin
                s_address    = r_j;
                s_data       = r_si;
                s_wren       = 1'b1;
                w_next_state = RD_F;
            end
            // After the swap S[i]+S[j] equals the pre-swap si+sj, so no re-read is needed.
            RD_F: begin
                s_address    = add8(r_si, r_sj);
                rom_address  = r_k;
                w_next_state = LATCH_F;
            end
            LATCH_F: begin
                out_address  = r_k;
                out_data     = s_q ^ rom_q;
                out_wren     = 1'b1;
                w_next_state = (r_k == K_LAST) ? DONE : INC_I;
            end
            DONE: begin
                done = 1'b1;
                if (w_accept) w_next_state = INC_I;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Directed bench for rc4_prga_decryptor with behavioural S memory, ciphertext ROM
// and a plaintext capture port.
module tb_rc4_prga_decryptor;
    import rc4_pkg::*;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic [7:0]  s_q;
    logic [4:0]  rom_address;
    logic [7:0]  rom_q;
    logic [4:0]  out_address;
    logic [7:0]  out_data;
    logic        out_wren;

    logic [7:0]  smem   [256];
    logic [7:0]  ld_img [256];
    logic [7:0]  m_s    [256];
    logic [7:0]  rom    [N];
    logic [7:0]  m_out  [N];
    logic [7:0]  obs    [N];
    logic [7:0]  wl_a   [64];
    logic [7:0]  wl_d   [64];
    logic        ld_req;

    int n_tests = 0;
    int n_fail  = 0;
    int wl_n, ow_n, both_n, addr_bad, lat;

    always #5 clk = ~clk;

    rc4_prga_decryptor #(.MSG_LEN(N)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .rom_address(rom_address), .rom_q(rom_q),
        .out_address(out_address), .out_data(out_data), .out_wren(out_wren)
    );

    always @(posedge clk) begin
        if (ld_req) begin
            for (int x = 0; x < 256; x++) smem[x] <= ld_img[x];
        end else if (s_wren) begin
            smem[s_address] <= s_data;
        end
        s_q   <= smem[s_address];
        rom_q <= rom[rom_address];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic identity_img();
        for (int x = 0; x < 256; x++) ld_img[x] = 8'(x);
    endtask

    task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] j, t, kb;
        identity_img();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            kb = (x % 3 == 0) ? k0 : ((x % 3 == 1) ? k1 : k2);
            j = j + ld_img[x] + kb;
            t = ld_img[x];
            ld_img[x] = ld_img[j];
            ld_img[j] = t;
        end
    endtask

    task automatic model_prga();
        logic [7:0] i, j, t, idx;
        for (int x = 0; x < 256; x++) m_s[x] = ld_img[x];
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < N; k++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
            idx = m_s[i] + m_s[j];
            m_out[k] = m_s[idx] ^ rom[k];
        end
    endtask

    task automatic load_s();
        @(negedge clk);
        ld_req = 1'b1;
        @(negedge clk);
        ld_req = 1'b0;
    endtask

    task automatic run(input bit mid);
        int n;
        wl_n = 0; ow_n = 0; both_n = 0; addr_bad = 0; lat = -1; n = 0;
        @(negedge clk);
        start = 1'b1;
        while (lat < 0 && n < 400) begin
            @(negedge clk);
            n++;
            start = mid && (n == 50);
            if (s_wren && wl_n < 64) begin
                wl_a[wl_n] = s_address;
                wl_d[wl_n] = s_data;
                wl_n++;
            end
            if (out_wren) begin
                if (ow_n != int'(out_address)) addr_bad++;
                obs[out_address] = out_data;
                ow_n++;
            end
            if (s_wren && out_wren) both_n++;
            if (done) lat = n - 1;
        end
        start = 1'b0;
    endtask

    function automatic int count_diff_model();
        int c = 0;
        for (int k = 0; k < N; k++) if (obs[k] !== m_out[k]) c++;
        return c;
    endfunction

    initial begin
        string pt;
        int    c;
        bit    found;
        pt     = "The quick brown fox jumps over t";
        reset  = 1'b1;
        start  = 1'b0;
        ld_req = 1'b0;
        for (int k = 0; k < N; k++) rom[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_wren", {s_wren, out_wren}, 0);
        chk("rst_s_bus", {s_address, s_data}, 0);
        chk("rst_rom_addr", rom_address, 0);
        chk("rst_out_bus", {out_address, out_data}, 0);
        reset = 1'b0;

        // Identity S, zero ciphertext
        identity_img();
        model_prga();
        load_s();
        run(1'b0);
        chk("id_out0", obs[0], 8'h02);
        chk("id_out1", obs[1], 8'h05);
        chk("id_b0_w0", {wl_a[0], wl_d[0]}, 16'h0101);
        chk("id_b0_w1", {wl_a[1], wl_d[1]}, 16'h0101);
        chk("id_b1_w0", {wl_a[2], wl_d[2]}, 16'h0203);
        chk("id_b1_w1", {wl_a[3], wl_d[3]}, 16'h0302);
        chk("id_latency", lat, 288);
        chk("id_out_pulses", ow_n, 32);
        chk("id_out_addr_seq", addr_bad, 0);
        chk("id_s_writes", wl_n, 64);
        chk("id_wren_overlap", both_n, 0);
        chk("id_bytes", count_diff_model(), 0);
        repeat (5) @(negedge clk);
        chk("done_hold", done, 1);

        // Restart from DONE with a stray start pulse mid-run
        identity_img();
        load_s();
        chk("done_before_restart", done, 1);
        run(1'b1);
        chk("mid_latency", lat, 288);
        chk("mid_out_pulses", ow_n, 32);
        chk("mid_bytes", count_diff_model(), 0);

        // Known-answer: key 00 02 49
        ksa(8'h00, 8'h02, 8'h49);
        for (int k = 0; k < N; k++) rom[k] = 8'h00;
        model_prga();
        for (int k = 0; k < N; k++) rom[k] = pt[k] ^ m_out[k];
        load_s();
        run(1'b0);
        c = 0;
        for (int k = 0; k < N; k++) if (obs[k] !== pt[k]) c++;
        chk("kat_byte0", obs[0], pt[0]);
        chk("kat_byte31", obs[31], pt[31]);
        chk("kat_bytes", c, 0);
        chk("kat_latency", lat, 288);

        // Reset landing in the first WR_SI of a run
        for (int k = 0; k < N; k++) rom[k] = 8'h00;
        identity_img();
        model_prga();
        load_s();
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (s_wren) found = 1'b1;
        end
        chk("wrsi_found", found, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_wren", {s_wren, out_wren}, 0);
        chk("midrst_s_bus", {s_address, s_data}, 0);
        chk("midrst_done", done, 0);
        c = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_wren || out_wren) c++;
        end
        chk("midrst_no_writes", c, 0);
        reset = 1'b0;
        identity_img();
        load_s();
        run(1'b0);
        chk("after_rst_out0", obs[0], 8'h02);
        chk("after_rst_out1", obs[1], 8'h05);
        chk("after_rst_first_wr", {wl_a[0], wl_d[0]}, 16'h0101);
        chk("after_rst_bytes", count_diff_model(), 0);
        chk("after_rst_latency", lat, 288);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decryptor.md
RC4_PRGA_DECRYPTOR -- requirements
Module: rc4_prga_decryptor

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, meaning number of ciphertext bytes processed per run (1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  pulse; begins a run when sampled high in IDLE or DONE.
REQ-005 SHALL have port done  output  1  high while in DONE.
REQ-006 SHALL have ports s_address, s_data, s_wren  output  8/8/1  S-memory address, write data and write enable.
REQ-007 SHALL have port s_q  input  8  S-memory read data, valid one cycle after s_address is driven.
REQ-008 SHALL have ports rom_address  output  5  ciphertext ROM address; rom_q  input  8  ciphertext byte, one-cycle latency.
REQ-009 SHALL have ports out_address  output  5, out_data  output  8, out_wren  output  1  plaintext RAM write port.

Function
REQ-010 SHALL implement the RC4 PRGA over an S array already filled by key scheduling: i=j=0; for k=0..MSG_LEN-1: i=i+1, j=j+S[i], swap S[i],S[j], out[k]=S[(S[i]+S[j]) mod 256] XOR rom[k].
REQ-011 SHALL perform all i, j and index arithmetic as 8-bit unsigned with wrap-around modulo 256.
REQ-012 SHALL use states IDLE, INC_I, RD_SI, LATCH_SI, RD_SJ, LATCH_SJ, WR_SI, WR_SJ, RD_F, LATCH_F, DONE, each lasting exactly one cycle except IDLE/DONE.
REQ-013 IDLE/DONE with start=1 SHALL clear i, j, k to 0 and go to INC_I; start=1 in any other state SHALL be ignored.
REQ-014 INC_I SHALL set i<=i+1; RD_SI SHALL drive s_address=i.
REQ-015 LATCH_SI SHALL register si<=s_q and j<=j+s_q; RD_SJ SHALL drive s_address=j (updated value).
REQ-016 LATCH_SJ SHALL register sj<=s_q.
REQ-017 WR_SI SHALL drive s_address=i, s_data=sj, s_wren=1; WR_SJ SHALL then drive s_address=j, s_data=si, s_wren=1 (when i==j both writes hit one address and S is unchanged).
REQ-018 RD_F SHALL drive s_address=si+sj and rom_address=k in the same cycle.
REQ-019 LATCH_F SHALL drive out_address=k, out_data=s_q XOR rom_q, out_wren=1; then go to DONE if k==MSG_LEN-1, else k<=k+1 and go to INC_I.
REQ-020 A run SHALL take exactly 9*MSG_LEN cycles from the first INC_I to entering DONE.
REQ-021 s_wren and out_wren SHALL be high only in WR_SI/WR_SJ and LATCH_F respectively; never both high in one cycle.
REQ-022 done SHALL stay high in DONE until reset or an accepted start.

Reset
REQ-023 reset SHALL immediately force state IDLE, i=j=k=si=sj=0, done=0, s_wren=0, out_wren=0, all address/data outputs 0.
REQ-024 reset mid-run SHALL abandon the run with no further writes; S contents SHALL NOT be restored.

Structure
REQ-025 State enum and MSG_LEN default SHALL live in shared package rc4_pkg, alongside the key-scheduling controller's constants.
REQ-026 SHALL be a single FSM plus datapath; no sub-module is required.

Verification
REQ-027 S identity (S[x]=x), ROM all 0x00, start -> out[0]=0x02, out[1]=0x05; byte-1 writes: addr 2 data 3, then addr 3 data 2.
REQ-028 start pulse with MSG_LEN=32 -> done rises exactly 288 cycles after first INC_I; exactly 32 out_wren pulses, addresses 0..31.
REQ-029 Byte 0 on identity S (i=j=1) -> two s_wren writes of 0x01 to address 1, S unchanged.
REQ-030 start re-asserted mid-run -> ignored, run completes in 288 cycles with unchanged outputs.
REQ-031 reset asserted in WR_SI -> outputs 0 same cycle, no out_wren; new start after release -> run begins from i=j=0.
REQ-032 Known-answer: S from KSA with key 0x000249, ROM holding reference ciphertext -> out RAM matches reference plaintext byte-for-byte.
